// File: rtl/uart_boot_loader.sv
// UART program-image loader: 8N1 receiver feeding a length-prefixed, little-endian word writer.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int D_WIDTH       = 32,
  parameter int D_DEPTH_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_rx,
  output logic [D_DEPTH_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0]       mem_data,
  output logic                     mem_en,
  output logic [3:0]               mem_wr_mask,
  output logic                     cpu_rst,
  output logic                     load_done,
  output logic                     frame_err,
  output logic                     checksum_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]   MAX_WORDS = 17'(1 << D_DEPTH_WIDTH);

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t rx_state, rx_next;

  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          byte_valid, rx_ferr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_s3 && !rx_s2) rx_next = RX_START;
      RX_START: if (clk_cnt == CNT_HALF) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (clk_cnt == CNT_FULL && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (clk_cnt == CNT_FULL) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      byte_valid <= (rx_state == RX_STOP) && (clk_cnt == CNT_FULL) && rx_s2;
      rx_ferr    <= (rx_state == RX_STOP) && (clk_cnt == CNT_FULL) && !rx_s2;
      case (rx_state)
        RX_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
        end
        RX_START: clk_cnt <= (clk_cnt == CNT_HALF) ? '0 : clk_cnt + 1'b1;
        RX_DATA: begin
          if (clk_cnt == CNT_FULL) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
            rx_byte <= {rx_s2, rx_byte[7:1]};
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: clk_cnt <= clk_cnt + 1'b1;
      endcase
    end
  end

  // ---------------- loader ----------------
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {L_LEN0, L_LEN1, L_DATA, L_CSUM, L_DONE, L_ERR} l_state_t;
  localparam l_state_t L_AFTER = L_CSUM;
`else
  typedef enum logic [2:0] {L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR} l_state_t;
  localparam l_state_t L_AFTER = L_DONE;
`endif
  l_state_t l_state, l_next;

  logic [7:0]  len_lo;
  logic [15:0] n_words, len_n;
  logic [1:0]  byte_cnt;
  logic        last_word, len_bad;

  assign len_n     = {rx_byte, len_lo};
  assign len_bad   = {1'b0, len_n} > MAX_WORDS;
  assign last_word = (16'(mem_addr) == n_words - 16'd1);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_ok;
  assign csum_ok = (rx_byte == csum);
`endif

  always_comb begin
    l_next = l_state;
    case (l_state)
      L_LEN0: if (rx_ferr) l_next = L_ERR; else if (byte_valid) l_next = L_LEN1;
      L_LEN1:
        if (rx_ferr) l_next = L_ERR;
        else if (byte_valid) begin
          if (len_n == 16'd0) l_next = L_AFTER;
          else if (len_bad)   l_next = L_ERR;
          else                l_next = L_DATA;
        end
      L_DATA: if (rx_ferr) l_next = L_ERR; else if (mem_en && last_word) l_next = L_AFTER;
`ifdef LOADER_CHECKSUM_EN
      L_CSUM: if (rx_ferr) l_next = L_ERR; else if (byte_valid) l_next = csum_ok ? L_DONE : L_ERR;
`endif
      default: l_next = l_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_state     <= L_LEN0;
      len_lo      <= '0;
      n_words     <= '0;
      byte_cnt    <= '0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_en      <= 1'b0;
      mem_wr_mask <= 4'b0000;
      cpu_rst     <= 1'b1;
      load_done   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      l_state     <= l_next;
      mem_en      <= 1'b0;
      mem_wr_mask <= 4'b0000;
      load_done   <= (l_state == L_DONE);
      cpu_rst     <= (l_state != L_DONE);
      if (l_state == L_LEN0 && byte_valid) len_lo <= rx_byte;
      if (l_state == L_LEN1 && byte_valid) n_words <= len_n;
      // Stop-bit errors after the image is settled are ignored with the rest of the stream.
      if ((rx_ferr && l_state != L_DONE) || (l_state == L_LEN1 && byte_valid && len_bad))
        frame_err <= 1'b1;
      if (l_state == L_DATA && byte_valid) begin
        mem_data <= {rx_byte, mem_data[D_WIDTH-1:8]};
        byte_cnt <= byte_cnt + 1'b1;
        if (byte_cnt == 2'd3) begin
          mem_en      <= 1'b1;
          mem_wr_mask <= 4'b1111;
        end
      end
      if (mem_en && !last_word) mem_addr <= mem_addr + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum         <= '0;
      checksum_err <= 1'b0;
    end else begin
      if (l_state == L_DATA && byte_valid) csum <= csum ^ rx_byte;
      if (l_state == L_CSUM && byte_valid && !csum_ok) checksum_err <= 1'b1;
    end
  end
`else
  assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomized and directed image loads against a queue-based model of expected RAM writes.
module tb_uart_boot_loader;
  localparam int CPB = 16;
  localparam int DW  = 10;

  logic          clk = 1'b0, rst = 1'b0, uart_rx = 1'b1;
  logic [DW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic          mem_en, cpu_rst, load_done, frame_err, checksum_err;
  logic [3:0]    mem_wr_mask;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .D_WIDTH(32), .D_DEPTH_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_en(mem_en), .mem_wr_mask(mem_wr_mask),
    .cpu_rst(cpu_rst), .load_done(load_done), .frame_err(frame_err), .checksum_err(checksum_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t        exp_q[$];
  int         tests = 0, fails = 0;
  logic       prev_en = 1'b0;
  logic [7:0] xsum;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every write must match the next expected (addr,data), be a single-cycle strobe with full mask.
  always @(negedge clk) begin
    if (!rst) begin
      chk("mask", 32'(mem_wr_mask), mem_en ? 32'hF : 32'h0);
      chk("cpu_rst_vs_done", 32'(cpu_rst), 32'(!load_done));
      if (mem_en) begin
        chk("en_one_cycle", 32'(prev_en), 32'h0);
        chk("write_expected", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          chk("wr_addr", 32'(mem_addr), exp_q[0].a);
          chk("wr_data", mem_data, exp_q[0].d);
          void'(exp_q.pop_front());
        end
      end
      prev_en = mem_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    @(negedge clk) uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 + $urandom_range(0, 6)) @(negedge clk);
  endtask

  task automatic send_payload(input logic [7:0] b);
    xsum ^= b;
    send_byte(b);
  endtask

  task automatic send_len(input logic [15:0] n);
    xsum = 8'h00;
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_data", mem_data, 32'h0);
    chk("rst_en", 32'(mem_en), 32'h0);
    chk("rst_mask", 32'(mem_wr_mask), 32'h0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("rst_done", 32'(load_done), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_cerr", 32'(checksum_err), 32'h0);
    exp_q.delete();
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic finish_img(input bit done, input bit ferr, input bit cerr);
    repeat (20) @(negedge clk);
    chk("writes_outstanding", 32'(exp_q.size()), 32'h0);
    chk("load_done", 32'(load_done), 32'(done));
    chk("cpu_rst", 32'(cpu_rst), 32'(!done));
    chk("frame_err", 32'(frame_err), 32'(ferr));
    chk("checksum_err", 32'(checksum_err), 32'(cerr));
  endtask

  task automatic random_image(input int n);
    logic [31:0] w;
    send_len(16'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_q.push_back('{a: 32'(i), d: w});
      for (int k = 0; k < 4; k++) send_payload(w[8*k +: 8]);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(xsum);
`endif
  endtask

  initial begin
    // Directed two-word image with hand-computed expectations.
    do_reset();
    exp_q.push_back('{a: 32'd0, d: 32'h12345678});
    exp_q.push_back('{a: 32'd1, d: 32'hDEADBEEF});
    send_len(16'h0002);
    send_payload(8'h78); send_payload(8'h56); send_payload(8'h34); send_payload(8'h12);
    send_payload(8'hEF); send_payload(8'hBE); send_payload(8'hAD);
    chk("done_before_last_word", 32'(load_done), 32'h0);
    send_payload(8'hDE);
`ifdef LOADER_CHECKSUM_EN
    chk("done_before_csum", 32'(load_done), 32'h0);
    send_byte(xsum);
`endif
    finish_img(1'b1, 1'b0, 1'b0);

    // Empty image.
    do_reset();
    send_len(16'h0000);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    chk("empty_done_prompt", 32'(load_done), 32'h1);
    finish_img(1'b1, 1'b0, 1'b0);

    // Bad stop bit in the payload; everything after it is ignored.
    do_reset();
    send_len(16'h0001);
    send_byte(8'hAA, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    finish_img(1'b0, 1'b1, 1'b0);

    // Length one past capacity.
    do_reset();
    send_len(16'h0401);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    finish_img(1'b0, 1'b1, 1'b0);

    // Short low glitch in idle must not desynchronise the following image.
    do_reset();
    @(negedge clk) uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_no_write_done", 32'(load_done), 32'h0);
    random_image(1);
    finish_img(1'b1, 1'b0, 1'b0);

    // Reset mid-byte, then a fresh image lands at address 0.
    do_reset();
    send_len(16'h0001);
    send_payload(8'h11); send_payload(8'h22);
    @(negedge clk) uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    do_reset();
    random_image(2);
    finish_img(1'b1, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    exp_q.push_back('{a: 32'd0, d: 32'h44332211});
    send_len(16'h0001);
    send_payload(8'h11); send_payload(8'h22); send_payload(8'h33); send_payload(8'h44);
    send_byte(8'h44);
    finish_img(1'b1, 1'b0, 1'b0);

    do_reset();
    exp_q.push_back('{a: 32'd0, d: 32'h44332211});
    send_len(16'h0001);
    send_payload(8'h11); send_payload(8'h22); send_payload(8'h33); send_payload(8'h44);
    send_byte(8'h45);
    finish_img(1'b0, 1'b0, 1'b1);
`endif

    // Randomized images.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      random_image($urandom_range(1, 6));
      finish_img(1'b1, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Upstream loader stage for the bit-serial core's instruction/data memory.
- Receives a program image over a UART RX line and assembles bytes into 32-bit little-endian words.
- Writes each word into the block RAM through that memory's masked-write port.
- Holds the control unit in reset until the image is fully loaded; the system-level address/data muxes select the loader while cpu_rst is high.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- D_WIDTH, 32, memory word width; fixed at 32, 4 bytes per word.
- D_DEPTH_WIDTH, 10, memory address width; capacity 2**D_DEPTH_WIDTH words.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- uart_rx  input  1  asynchronous serial line, idle high, 8N1
- mem_addr  output  D_DEPTH_WIDTH  word address to block RAM
- mem_data  output  D_WIDTH  write data to block RAM
- mem_en  output  1  memory enable, one-cycle write strobe
- mem_wr_mask  output  4  byte write mask; 4'b1111 during a write, else 4'b0000
- cpu_rst  output  1  reset to control unit; high until load completes
- load_done  output  1  high once image is written successfully (sticky)
- frame_err  output  1  sticky; stop bit sampled low, or length out of range
- checksum_err  output  1  sticky checksum mismatch; tied 0 unless the macro is defined

Behaviour:
Reset:
- rst asserted, asynchronous: mem_addr=0, mem_data=0, mem_en=0, mem_wr_mask=0, cpu_rst=1, load_done=0, frame_err=0, checksum_err=0.
- Both FSMs go to their initial states; all counters clear.
- Reset mid-load abandons the image; already-written words stay in RAM.

Input synchroniser:
- 2-flop synchroniser on uart_rx, reset to 1.

RX FSM: RX_IDLE → RX_START → RX_DATA → RX_STOP.
- RX_IDLE: a falling edge of the synchronised line starts the bit counter and moves to RX_START.
- RX_START: sample at CLKS_PER_BIT/2. Low → RX_DATA. High → false start, back to RX_IDLE with no byte.
- RX_DATA: 8 samples, each CLKS_PER_BIT apart, LSB first.
- RX_STOP: sample one bit period later.
  - High → byte_valid pulses for 1 cycle.
  - Low → frame_err=1, byte discarded.
  - Either way → RX_IDLE.

Loader FSM: L_LEN0 → L_LEN1 → L_DATA → [L_CSUM] → L_DONE; error state L_ERR.
- L_LEN0 / L_LEN1: capture 16-bit word count N, little-endian (low byte first).
- After L_LEN1, range check on N:
  - N=0 → L_DONE directly.
  - N > 2**D_DEPTH_WIDTH → frame_err=1, go to L_ERR.
- L_DATA: bytes shift into mem_data little-endian; byte k of a word lands in bits [8k+7:8k].
  - On the 4th byte_valid of a word, the next cycle drives mem_en=1 and mem_wr_mask=4'b1111 for exactly one cycle.
  - During that cycle mem_addr = current word index and mem_data is stable.
  - The following cycle mem_en and mem_wr_mask return to 0 and mem_addr increments.
  - The last address written is N-1; the address counter never wraps because N is range-checked.
  - After word N is written → L_CSUM if enabled, else L_DONE.
- L_DONE: load_done=1, cpu_rst=0 on the cycle after entry. Terminal until rst; further RX bytes are ignored.
- L_ERR: cpu_rst stays 1, load_done stays 0. Terminal until rst.
- A frame error in any L_ state → L_ERR.
- Byte-level write latency: byte_valid of the 4th byte → write strobe in 1 cycle.
- A byte arriving during the write cycle is impossible because CLKS_PER_BIT ≥ 4; no buffering is required.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers all 4N payload bytes.
  - L_CSUM receives one trailing byte.
  - Match → L_DONE.
  - Mismatch → checksum_err=1, go to L_ERR.
  - With N=0, the expected checksum byte is 0x00.
- Not defined: no L_CSUM state, no XOR register, checksum_err tied 0, L_DATA goes straight to L_DONE.

Test Plan:
- CLKS_PER_BIT=16: send 02 00 | 78 56 34 12 | EF BE AD DE → writes addr0=0x12345678 and addr1=0xDEADBEEF, each with a 1-cycle mem_en and mask 4'b1111; cpu_rst falls after the 2nd write; load_done=1.
- Send 00 00 → no memory writes; load_done=1 and cpu_rst=0 within 2 cycles of the 2nd stop bit.
- Send 01 00 then a byte whose stop bit is driven low → frame_err=1, no write, cpu_rst stays 1; the next bytes are ignored.
- Send 01 04 (N=1025) → frame_err=1, L_ERR, no writes.
- 3-cycle low glitch on uart_rx in RX_IDLE → no byte and no state change; rst asserted during the 3rd payload byte → all outputs at reset values immediately; a fresh image then loads from addr 0.
- With LOADER_CHECKSUM_EN: payload 01 00 11 22 33 44 with checksum 0x44 → done; checksum 0x45 → checksum_err=1 and cpu_rst stays 1; the word is already written at addr0=0x44332211.
